// File: rtl/data_port_arbiter.sv
// Two-requester (host core / vector LSU) arbiter onto a single shared data
// port. Round-robin on ties, selection locked while a request waits for
// grant, and an in-order ID FIFO routes responses back to the issuer.
module data_port_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        n_reset,

  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [31:0] core_addr_i,
  input  logic [3:0]  core_be_i,
  input  logic [31:0] core_wdata_i,
  output logic        core_gnt_o,
  output logic        core_rvalid_o,
  output logic [31:0] core_rdata_o,

  input  logic        vlsu_req_i,
  input  logic        vlsu_we_i,
  input  logic [31:0] vlsu_addr_i,
  input  logic [3:0]  vlsu_be_i,
  input  logic [31:0] vlsu_wdata_i,
  output logic        vlsu_gnt_o,
  output logic        vlsu_rvalid_o,
  output logic [31:0] vlsu_rdata_o,

  output logic        data_req_o,
  output logic        data_we_o,
  output logic [31:0] data_addr_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,

  output logic [2:0]  outstanding_o,
  output logic        err_o
);

  localparam int unsigned PTR_W = 2;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned SLOTS = 4;

  localparam logic ID_CORE = 1'b0;
  localparam logic ID_VLSU = 1'b1;

  logic [CNT_W-1:0] count_q,    count_d;
  logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [SLOTS-1:0] fifo_q,     fifo_d;
  logic             lock_valid_q, lock_valid_d;
  logic             lock_id_q,    lock_id_d;
  logic             last_grant_q, last_grant_d;
  logic             err_q,        err_d;

  logic sel_id;
  logic sel_req;
  logic can_issue;
  logic grant;
  logic pop;
  logic head_id;

  // Pointers wrap at the configured depth, not at the storage size.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Requester selection: lock first, then round-robin tie-break, then single requester.
  always_comb begin
    sel_id  = ID_CORE;
    sel_req = 1'b0;
    if (lock_valid_q) begin
      sel_id  = lock_id_q;
      sel_req = (lock_id_q == ID_VLSU) ? vlsu_req_i : core_req_i;
    end else if (core_req_i && vlsu_req_i) begin
      sel_id  = ~last_grant_q;
      sel_req = 1'b1;
    end else if (core_req_i) begin
      sel_id  = ID_CORE;
      sel_req = 1'b1;
    end else if (vlsu_req_i) begin
      sel_id  = ID_VLSU;
      sel_req = 1'b1;
    end
  end

  // Shared-port request mux, grant fan-out and response routing.
  always_comb begin
    can_issue    = !n_reset && (count_q < CNT_W'(MAX_OUTSTANDING));
    data_req_o   = can_issue && sel_req;
    data_we_o    = 1'b0;
    data_addr_o  = '0;
    data_be_o    = '0;
    data_wdata_o = '0;
    if (data_req_o) begin
      data_we_o    = (sel_id == ID_VLSU) ? vlsu_we_i    : core_we_i;
      data_addr_o  = (sel_id == ID_VLSU) ? vlsu_addr_i  : core_addr_i;
      data_be_o    = (sel_id == ID_VLSU) ? vlsu_be_i    : core_be_i;
      data_wdata_o = (sel_id == ID_VLSU) ? vlsu_wdata_i : core_wdata_i;
    end
    grant      = data_req_o && data_gnt_i;
    core_gnt_o = grant && (sel_id == ID_CORE);
    vlsu_gnt_o = grant && (sel_id == ID_VLSU);

    head_id       = fifo_q[rd_ptr_q];
    pop           = !n_reset && data_rvalid_i && (count_q != '0);
    core_rvalid_o = pop && (head_id == ID_CORE);
    vlsu_rvalid_o = pop && (head_id == ID_VLSU);
    core_rdata_o  = core_rvalid_o ? data_rdata_i : '0;
    vlsu_rdata_o  = vlsu_rvalid_o ? data_rdata_i : '0;
  end

  // Next-state: ID FIFO push/pop, lock tracking, round-robin history, error flag.
  always_comb begin
    count_d      = count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_d       = fifo_q;
    lock_valid_d = lock_valid_q;
    lock_id_d    = lock_id_q;
    last_grant_d = last_grant_q;
    err_d        = err_q;

    if (grant) begin
      fifo_d[wr_ptr_q] = sel_id;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
      last_grant_d     = sel_id;
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    count_d = count_q + CNT_W'(grant) - CNT_W'(pop);

    if (data_req_o) begin
      lock_valid_d = !data_gnt_i;
      lock_id_d    = sel_id;
    end else if (lock_valid_q && !sel_req) begin
      lock_valid_d = 1'b0;
    end

    if (data_rvalid_i && (count_q == '0)) begin
      err_d = 1'b1;
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (n_reset) begin
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_q       <= '0;
      lock_valid_q <= 1'b0;
      lock_id_q    <= ID_CORE;
      last_grant_q <= ID_VLSU;
      err_q        <= 1'b0;
    end else begin
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_q       <= fifo_d;
      lock_valid_q <= lock_valid_d;
      lock_id_q    <= lock_id_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
    end
  end

  assign outstanding_o = count_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_data_port_arbiter.sv
// Scoreboard bench for data_port_arbiter: expected issuer IDs are queued
// when a grant is expected and popped when the bench returns a response.
module tb_data_port_arbiter;

  localparam logic [31:0] CORE_ADDR  = 32'h0000_1000;
  localparam logic [31:0] VLSU_ADDR  = 32'h0000_2000;
  localparam logic [31:0] CORE_WDATA = 32'hC0C0_0001;
  localparam logic [31:0] VLSU_WDATA = 32'h5A5A_0002;
  localparam logic [3:0]  CORE_BE    = 4'hF;
  localparam logic [3:0]  VLSU_BE    = 4'h3;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        core_req_i, core_we_i, vlsu_req_i, vlsu_we_i;
  logic [31:0] core_addr_i, core_wdata_i, vlsu_addr_i, vlsu_wdata_i;
  logic [3:0]  core_be_i, vlsu_be_i;
  logic        core_gnt_o, core_rvalid_o, vlsu_gnt_o, vlsu_rvalid_o;
  logic [31:0] core_rdata_o, vlsu_rdata_o;
  logic        data_req_o, data_we_o;
  logic [31:0] data_addr_o, data_wdata_o;
  logic [3:0]  data_be_o;
  logic        data_gnt_i, data_rvalid_i;
  logic [31:0] data_rdata_i;
  logic [2:0]  outstanding_o;
  logic        err_o;

  int n_tests = 0;
  int n_fail  = 0;
  bit exp_err = 1'b0;
  bit exp_q[$];

  always #5 clk = ~clk;

  data_port_arbiter #(.MAX_OUTSTANDING(2)) dut (
    .clk(clk), .n_reset(n_reset),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_addr_i(core_addr_i),
    .core_be_i(core_be_i), .core_wdata_i(core_wdata_i),
    .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
    .vlsu_req_i(vlsu_req_i), .vlsu_we_i(vlsu_we_i), .vlsu_addr_i(vlsu_addr_i),
    .vlsu_be_i(vlsu_be_i), .vlsu_wdata_i(vlsu_wdata_i),
    .vlsu_gnt_o(vlsu_gnt_o), .vlsu_rvalid_o(vlsu_rvalid_o), .vlsu_rdata_o(vlsu_rdata_o),
    .data_req_o(data_req_o), .data_we_o(data_we_o), .data_addr_o(data_addr_o),
    .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
    .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One cycle of stimulus. exp_sel: -1 no request on the port, 0 core, 1 vlsu.
  task automatic step(input string tag, input bit creq, input bit vreq, input bit gnt,
                      input bit rv, input logic [31:0] rdata, input int exp_sel);
    bit id;
    core_req_i    = creq;
    vlsu_req_i    = vreq;
    data_gnt_i    = gnt;
    data_rvalid_i = rv;
    data_rdata_i  = rdata;
    #1;
    check({tag, ".outstanding"}, 32'(outstanding_o), 32'(exp_q.size()));
    check({tag, ".err"}, 32'(err_o), 32'(exp_err));
    check({tag, ".req"}, 32'(data_req_o), 32'(exp_sel >= 0));
    check({tag, ".core_gnt"}, 32'(core_gnt_o), 32'(gnt && exp_sel == 0));
    check({tag, ".vlsu_gnt"}, 32'(vlsu_gnt_o), 32'(gnt && exp_sel == 1));
    if (exp_sel == 0) begin
      check({tag, ".addr"},  data_addr_o, CORE_ADDR);
      check({tag, ".wdata"}, data_wdata_o, CORE_WDATA);
      check({tag, ".be_we"}, {27'd0, data_be_o, data_we_o}, {27'd0, CORE_BE, 1'b1});
    end else if (exp_sel == 1) begin
      check({tag, ".addr"},  data_addr_o, VLSU_ADDR);
      check({tag, ".wdata"}, data_wdata_o, VLSU_WDATA);
      check({tag, ".be_we"}, {27'd0, data_be_o, data_we_o}, {27'd0, VLSU_BE, 1'b0});
    end
    if (rv && exp_q.size() > 0) begin
      id = exp_q.pop_front();
      check({tag, ".core_rvalid"}, 32'(core_rvalid_o), 32'(id == 1'b0));
      check({tag, ".vlsu_rvalid"}, 32'(vlsu_rvalid_o), 32'(id == 1'b1));
      check({tag, ".core_rdata"}, core_rdata_o, (id == 1'b0) ? rdata : 32'd0);
      check({tag, ".vlsu_rdata"}, vlsu_rdata_o, (id == 1'b1) ? rdata : 32'd0);
    end else if (rv) begin
      check({tag, ".stray_rvalid"}, {30'd0, core_rvalid_o, vlsu_rvalid_o}, 32'd0);
    end
    if (gnt && exp_sel >= 0) exp_q.push_back(exp_sel[0]);
    @(posedge clk);
    #1;
    if (rv && !gnt && exp_sel < 0 && exp_q.size() == 0 && !exp_err) begin
      exp_err = exp_err;
    end
  endtask

  // Stray-response step: a response arriving with nothing outstanding sets the error flag.
  task automatic stray(input string tag, input logic [31:0] rdata);
    step(tag, 1'b0, 1'b0, 1'b0, 1'b1, rdata, -1);
    exp_err = 1'b1;
  endtask

  // Reset cycle with live inputs; port-side outputs must be forced off.
  task automatic do_reset(input string tag);
    n_reset       = 1'b1;
    core_req_i    = 1'b1;
    vlsu_req_i    = 1'b1;
    data_gnt_i    = 1'b1;
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'hFFFF_FFFF;
    #1;
    check({tag, ".rst_req"}, 32'(data_req_o), 32'd0);
    check({tag, ".rst_gnt"}, {30'd0, core_gnt_o, vlsu_gnt_o}, 32'd0);
    check({tag, ".rst_rvalid"}, {30'd0, core_rvalid_o, vlsu_rvalid_o}, 32'd0);
    @(posedge clk);
    #1;
    n_reset = 1'b0;
    exp_q.delete();
    exp_err = 1'b0;
    core_req_i    = 1'b0;
    vlsu_req_i    = 1'b0;
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
    #1;
    check({tag, ".rst_outstanding"}, 32'(outstanding_o), 32'd0);
    check({tag, ".rst_err"}, 32'(err_o), 32'd0);
  endtask

  initial begin
    n_reset      = 1'b1;
    core_we_i    = 1'b1;
    core_addr_i  = CORE_ADDR;
    core_be_i    = CORE_BE;
    core_wdata_i = CORE_WDATA;
    vlsu_we_i    = 1'b0;
    vlsu_addr_i  = VLSU_ADDR;
    vlsu_be_i    = VLSU_BE;
    vlsu_wdata_i = VLSU_WDATA;
    @(posedge clk);
    #1;
    do_reset("reset");

    // Both requesting, grant every cycle, response one cycle later: alternating.
    for (int k = 0; k < 5; k++) begin
      step("rr", 1'b1, 1'b1, 1'b1, k > 0, 32'hA000_0000 + 32'(k), k % 2);
    end
    step("rr_drain", 1'b0, 1'b0, 1'b0, 1'b1, 32'hA000_0005, -1);

    // Last grant was core; lock keeps core selected against the tie while stalled.
    step("lock0", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 0);
    step("lock1", 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 0);
    step("lock2", 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 0);
    step("lock3", 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 0);
    step("lock4", 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1);
    step("lock_r0", 1'b0, 1'b0, 1'b0, 1'b1, 32'hB000_0001, -1);
    step("lock_r1", 1'b0, 1'b0, 1'b0, 1'b1, 32'hB000_0002, -1);

    // Locked requester drops req: lock released without a grant.
    step("drop0", 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1);
    step("drop1", 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, -1);
    step("drop2", 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 0);
    step("drop3", 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 0);
    step("drop_r", 1'b0, 1'b0, 1'b0, 1'b1, 32'hC000_0001, -1);

    // Outstanding limit: full blocks issue, including the cycle a response arrives.
    step("full0", 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 0);
    step("full1", 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 0);
    step("full2", 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, -1);
    step("full3", 1'b1, 1'b0, 1'b1, 1'b1, 32'hD000_0001, -1);
    step("full4", 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 0);
    step("full_r0", 1'b0, 1'b0, 1'b0, 1'b1, 32'hD000_0002, -1);
    step("full_r1", 1'b0, 1'b0, 1'b0, 1'b1, 32'hD000_0003, -1);

    // In-order routing: vlsu then core reads.
    step("ord0", 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1);
    step("ord1", 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 0);
    step("ord_r0", 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, -1);
    step("ord_r1", 1'b0, 1'b0, 1'b0, 1'b1, 32'h1234_5678, -1);

    // Stray response sets the sticky error flag; reset clears it.
    stray("stray0", 32'hEEEE_0001);
    step("err_hold0", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, -1);
    step("err_hold1", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, -1);
    do_reset("err_reset");

    // Reset mid-operation with two outstanding and last grant core.
    step("mid0", 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1);
    step("mid1", 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 0);
    do_reset("mid_reset");
    step("post0", 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 0);
    step("post_r", 1'b0, 1'b0, 1'b0, 1'b1, 32'hF000_0001, -1);
    stray("post_stray", 32'hF000_0002);
    step("post_err", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
